// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around a single 4-bit ripple-carry stage.
// Operands are captured once and then added one nibble per cycle, LSB first.
// The slice carry is registered between cycles, so a/b never reach sum combinationally.

// 4-bit ripple-carry stage, reused for every slice.
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int SLICES = WIDTH / 4;
    localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;

    // Refuse to elaborate for widths that do not split into whole nibbles.
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDXW-1:0]  idx;

    logic [3:0]       a_slices [SLICES];
    logic [3:0]       b_slices [SLICES];
    logic [3:0]       a_sl;
    logic [3:0]       b_sl;
    logic [3:0]       s_sl;
    logic             c_sl;
    logic             c_msb;

    // Break the captured operands into nibbles so the active one can be picked by index.
    for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
        assign a_slices[gi] = a_reg[4*gi +: 4];
        assign b_slices[gi] = b_reg[4*gi +: 4];
    end

    assign a_sl = a_slices[idx];
    assign b_sl = b_slices[idx];

    rca u_rca (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_reg),
        .sum  (s_sl),
        .cout (c_sl)
    );

    // Carry into the top bit of the slice; only meaningful on the last slice, for overflow.
    assign c_msb = a_sl[3] ^ b_sl[3] ^ s_sl[3];

    // Control FSM with operand staging, slice sequencing and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= ADD;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= s_sl;
                    carry_reg       <= c_sl;
                    idx             <= idx + 1'b1;
                    if (idx == IDXW'(SLICES - 1)) begin
                        idx       <= '0;
                        cout      <= c_sl;
                        ovf       <= c_msb ^ c_sl;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it; no accept in the same edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector table,
// backpressure and mid-operation reset sequences, and a randomized scoreboard run.
module tb_nibble_serial_adder;
    localparam int WIDTH  = 16;
    localparam int SLICES = WIDTH / 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_res  = 0;
    int or_mode = 1;   // 0: out_ready low, 1: out_ready high, 2: random stalls

    vec_t pending;
    vec_t exp_q[$];
    int   acc_q[$];

    logic        ov_prev = 1'b0;
    logic [15:0] hold_sum;
    logic        hold_cout;
    logic        hold_ovf;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic vec_t model(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        vec_t        v;
        logic [16:0] full;
        full   = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
        v.a    = ta;
        v.b    = tb;
        v.cin  = tc;
        v.sum  = full[15:0];
        v.cout = full[16];
        v.ovf  = (ta[15] == tb[15]) && (full[15] != ta[15]);
        return v;
    endfunction

    // out_ready generator, applied a little after the drive phase of each cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: samples on the falling edge, i.e. the values that the next rising edge will act on
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("out_valid_in_reset", {31'd0, out_valid}, 32'd0);
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(pending);
                acc_q.push_back(cyc + 1);
                n_acc++;
            end
            if (out_valid) begin
                chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                chk("busy_in_done", {31'd0, busy}, 32'd1);
            end
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
                else chk("latency", cyc - acc_q[0], SLICES);
            end
            if (out_valid && ov_prev) begin
                chk("hold_sum", {16'd0, sum}, {16'd0, hold_sum});
                chk("hold_cout", {31'd0, cout}, {31'd0, hold_cout});
                chk("hold_ovf", {31'd0, ovf}, {31'd0, hold_ovf});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    n_res++;
                    chk("sum", {16'd0, sum}, {16'd0, e.sum});
                    chk("cout", {31'd0, cout}, {31'd0, e.cout});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    $display("txn %0d a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b",
                             n_res, e.a, e.b, e.cin, sum, cout, ovf);
                end
            end
        end
        hold_sum  <= sum;
        hold_cout <= cout;
        hold_ovf  <= ovf;
        ov_prev   <= out_valid && rst_n && !out_ready;
    end

    // Present one operand set and wait (bounded) until it is accepted; runs in the posedge+1 phase
    task automatic drive(input vec_t e);
        int budget;
        budget   = 0;
        a        = e.a;
        b        = e.b;
        cin      = e.cin;
        pending  = e;
        in_valid = 1'b1;
        while (!in_ready && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("drain_timeout", {31'd0, (exp_q.size() != 0 || busy)}, 32'd0);
    endtask

    vec_t table_v [7];

    initial begin
        int budget;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        or_mode  = 1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results
        table_v[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        table_v[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        table_v[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        table_v[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        table_v[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        table_v[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        table_v[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) drive(table_v[i]);
        drain();

        // Backpressure: result must hold while operands wiggle and in_valid is asserted
        or_mode = 0;
        drive('{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0});
        budget = 0;
        while (!out_valid && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
            pending  = model(a, b, cin);
            @(posedge clk);
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum", {16'd0, sum}, 32'h5556);
        end
        a       = 16'h0F0F;
        b       = 16'h1010;
        cin     = 1'b0;
        pending = '{16'h0F0F, 16'h1010, 1'b0, 16'h1F1F, 1'b0, 1'b0};
        or_mode = 1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_no_same_edge_accept", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_next_edge", {31'd0, busy}, 32'd1);
        drain();

        // Asynchronous reset two cycles into an addition
        drive('{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_sum", {16'd0, sum}, 32'd0);
        chk("arst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        n_acc -= exp_q.size();
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive('{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0});
        drain();

        // Random regression with consumer stalls
        or_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            vec_t v;
            v = model(16'($urandom), 16'($urandom), 1'($urandom));
            drive(v);
        end
        or_mode = 1;
        drain();

        chk("results_vs_accepts", n_res, n_acc);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
